global_buffer_bank: RTL and testbench

Banked on-chip feature-map global buffer that answers the systolic wrapper's memory traffic. It serves broadcast-address reads for the input buffer, independent per-channel writes from the result handler, and a host load/readback port. It also provides a zero-fill sweep used before each layer. It sits between the host/DMA and the systolic wrapper's gb_rd_* / gb_wr_* ports.

---
 rtl/global_buffer_bank_if.sv | 53 +++++
 rtl/global_buffer_bank.sv | 187 ++++++++++++++++++
 tb/tb_global_buffer_bank.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/global_buffer_bank_if.sv
// Bus bundle for the global buffer bank: accelerator read/write ports,
// host load/readback port and zero-fill control.
interface global_buffer_bank_if #(
  parameter int unsigned K_CH   = 6,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned BSEL_W = $clog2(K_CH > 1 ? K_CH : 2)
);

  logic [K_CH-1:0]        acc_rd_en_i;
  logic [ADDR_W-1:0]      acc_rd_addr_i;
  logic [K_CH*DATA_W-1:0] acc_rd_data_o;
  logic [K_CH-1:0]        acc_rd_valid_o;

  logic [K_CH-1:0]        acc_wr_en_i;
  logic [K_CH*ADDR_W-1:0] acc_wr_addr_i;
  logic [K_CH*DATA_W-1:0] acc_wr_data_i;

  logic                   host_req_i;
  logic                   host_we_i;
  logic [BSEL_W-1:0]      host_bank_i;
  logic [ADDR_W-1:0]      host_addr_i;
  logic [DATA_W-1:0]      host_wdata_i;
  logic                   host_gnt_o;
  logic                   host_rvalid_o;
  logic [DATA_W-1:0]      host_rdata_o;

  logic                   clear_start_i;
  logic                   clear_busy_o;
  logic                   clear_done_o;
  logic                   err_o;

  modport slave (
    input  acc_rd_en_i, acc_rd_addr_i,
    output acc_rd_data_o, acc_rd_valid_o,
    input  acc_wr_en_i, acc_wr_addr_i, acc_wr_data_i,
    input  host_req_i, host_we_i, host_bank_i, host_addr_i, host_wdata_i,
    output host_gnt_o, host_rvalid_o, host_rdata_o,
    input  clear_start_i,
    output clear_busy_o, clear_done_o, err_o
  );

  modport master (
    output acc_rd_en_i, acc_rd_addr_i,
    input  acc_rd_data_o, acc_rd_valid_o,
    output acc_wr_en_i, acc_wr_addr_i, acc_wr_data_i,
    output host_req_i, host_we_i, host_bank_i, host_addr_i, host_wdata_i,
    input  host_gnt_o, host_rvalid_o, host_rdata_o,
    output clear_start_i,
    input  clear_busy_o, clear_done_o, err_o
  );

endinterface

// File: rtl/global_buffer_bank.sv
// Banked feature-map global buffer: per-channel 1R1W banks with a broadcast-address
// accelerator read, per-bank accelerator writes, an arbitrated host port and a zero-fill sweep.
module global_buffer_bank #(
  parameter int unsigned K_CH   = 6,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned BSEL_W = $clog2(K_CH > 1 ? K_CH : 2)
) (
  input logic                  clk_i,
  input logic                  rst_async_i,
  global_buffer_bank_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic [K_CH*DATA_W-1:0] rd_data_q, rd_data_d;
  logic [K_CH-1:0]        rd_valid_q, rd_valid_d;
  logic                   host_rvalid_q, host_rvalid_d;
  logic [DATA_W-1:0]      host_rdata_q, host_rdata_d;

  logic [DATA_W-1:0] mem_q [K_CH][DEPTH];

  logic [K_CH-1:0]   host_sel_c;
  logic              host_bank_ok_c;
  logic              host_conflict_c;
  logic              host_gnt_c;
  logic              host_wr_c;
  logic              host_rd_c;

  logic [K_CH-1:0]   wr_en_c;
  logic [ADDR_W-1:0] wr_addr_c [K_CH];
  logic [DATA_W-1:0] wr_data_c [K_CH];

  // Host arbitration: accelerator traffic on the target bank and the sweep both win.
  always_comb begin
    host_sel_c      = '0;
    host_conflict_c = 1'b0;
    host_bank_ok_c  = (32'(bus.host_bank_i) < K_CH);
    for (int unsigned b = 0; b < K_CH; b++) begin
      host_sel_c[b] = (bus.host_bank_i == BSEL_W'(b));
      if (host_sel_c[b] && (bus.acc_rd_en_i[b] || bus.acc_wr_en_i[b])) begin
        host_conflict_c = 1'b1;
      end
    end
    host_gnt_c = bus.host_req_i & ~busy_q & ~host_conflict_c & ~rst_async_i;
    host_wr_c  = host_gnt_c & bus.host_we_i & host_bank_ok_c;
    host_rd_c  = host_gnt_c & ~bus.host_we_i;
  end

  // Per-bank write port mux: sweep, then accelerator, then host.
  always_comb begin
    for (int unsigned b = 0; b < K_CH; b++) begin
      wr_en_c[b]   = 1'b0;
      wr_addr_c[b] = '0;
      wr_data_c[b] = '0;
      if (state_q == ST_CLEAR) begin
        wr_en_c[b]   = 1'b1;
        wr_addr_c[b] = cnt_q[ADDR_W-1:0];
      end else if (bus.acc_wr_en_i[b]) begin
        wr_en_c[b]   = 1'b1;
        wr_addr_c[b] = bus.acc_wr_addr_i[b*ADDR_W +: ADDR_W];
        wr_data_c[b] = bus.acc_wr_data_i[b*DATA_W +: DATA_W];
      end else if (host_wr_c && host_sel_c[b]) begin
        wr_en_c[b]   = 1'b1;
        wr_addr_c[b] = bus.host_addr_i;
        wr_data_c[b] = bus.host_wdata_i;
      end
    end
  end

  // Bank storage carries no reset; contents survive reset.
  always_ff @(posedge clk_i) begin
    for (int unsigned b = 0; b < K_CH; b++) begin
      if (wr_en_c[b]) begin
        mem_q[b][wr_addr_c[b]] <= wr_data_c[b];
      end
    end
  end

  // Read paths sample the array before this edge's writes, giving read-first behaviour.
  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = bus.acc_rd_en_i;
    for (int unsigned b = 0; b < K_CH; b++) begin
      if (bus.acc_rd_en_i[b]) begin
        rd_data_d[b*DATA_W +: DATA_W] = mem_q[b][bus.acc_rd_addr_i];
      end
    end

    host_rvalid_d = host_rd_c;
    host_rdata_d  = host_rdata_q;
    if (host_rd_c) begin
      host_rdata_d = '0;
      for (int unsigned b = 0; b < K_CH; b++) begin
        if (host_sel_c[b]) begin
          host_rdata_d = mem_q[b][bus.host_addr_i];
        end
      end
    end
  end

  // Zero-fill sweep next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.clear_start_i) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DEPTH - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_CLEAR);
    done_d = (state_d == ST_DONE);
  end

  // Sticky error: accelerator write lost to the sweep, or host access to a missing bank.
  always_comb begin
    err_d = err_q;
    if ((state_q == ST_CLEAR) && (|bus.acc_wr_en_i)) begin
      err_d = 1'b1;
    end
    if (host_gnt_c && !host_bank_ok_c) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_async_i) begin
    if (rst_async_i) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      rd_data_q     <= '0;
      rd_valid_q    <= '0;
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
      rd_data_q     <= rd_data_d;
      rd_valid_q    <= rd_valid_d;
      host_rvalid_q <= host_rvalid_d;
      host_rdata_q  <= host_rdata_d;
    end
  end

  assign bus.acc_rd_data_o  = rd_data_q;
  assign bus.acc_rd_valid_o = rd_valid_q;
  assign bus.host_gnt_o     = host_gnt_c;
  assign bus.host_rvalid_o  = host_rvalid_q;
  assign bus.host_rdata_o   = host_rdata_q;
  assign bus.clear_busy_o   = busy_q;
  assign bus.clear_done_o   = done_q;
  assign bus.err_o          = err_q;

endmodule

// File: tb/tb_global_buffer_bank.sv
// Scoreboard bench for global_buffer_bank with a 16-word bank depth.
module tb_global_buffer_bank;

  localparam int unsigned K  = 6;
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;

  typedef struct {
    logic [K-1:0]    mask;
    logic [K*DW-1:0] data;
    int              due;
  } acc_exp_t;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } host_exp_t;

  logic clk;
  logic rst;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  acc_exp_t  acc_q[$];
  host_exp_t host_q[$];

  global_buffer_bank_if #(.K_CH(K), .ADDR_W(AW), .DATA_W(DW)) bus ();

  global_buffer_bank #(.K_CH(K), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i       (clk),
    .rst_async_i (rst),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.acc_rd_en_i   = '0;
    bus.acc_rd_addr_i = '0;
    bus.acc_wr_en_i   = '0;
    bus.acc_wr_addr_i = '0;
    bus.acc_wr_data_i = '0;
    bus.host_req_i    = 1'b0;
    bus.host_we_i     = 1'b0;
    bus.host_bank_i   = '0;
    bus.host_addr_i   = '0;
    bus.host_wdata_i  = '0;
    bus.clear_start_i = 1'b0;
  endtask

  task automatic set_wr(input int b, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.acc_wr_en_i[b]              = 1'b1;
    bus.acc_wr_addr_i[b*AW +: AW]   = a;
    bus.acc_wr_data_i[b*DW +: DW]   = d;
  endtask

  task automatic rd(input logic [K-1:0] mask, input logic [AW-1:0] a, input logic [K*DW-1:0] exp);
    acc_exp_t e;
    bus.acc_rd_en_i   = mask;
    bus.acc_rd_addr_i = a;
    e.mask = mask;
    e.data = exp;
    e.due  = cyc + 1;
    acc_q.push_back(e);
  endtask

  task automatic host(input logic we, input logic [2:0] bank, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd);
    bus.host_req_i   = 1'b1;
    bus.host_we_i    = we;
    bus.host_bank_i  = bank;
    bus.host_addr_i  = a;
    bus.host_wdata_i = wd;
  endtask

  task automatic host_expect(input logic [DW-1:0] d);
    host_exp_t e;
    e.data = d;
    e.due  = cyc + 1;
    host_q.push_back(e);
  endtask

  // Monitor: pops expected responses whenever the DUT presents read data.
  always @(negedge clk) begin
    if (!rst) begin
      while (acc_q.size() > 0 && acc_q[0].due < cyc) begin
        total++; bad++;
        $display("FAIL acc_rd_missing: no valid at cycle %0d", acc_q[0].due);
        void'(acc_q.pop_front());
      end
      while (host_q.size() > 0 && host_q[0].due < cyc) begin
        total++; bad++;
        $display("FAIL host_rd_missing: no rvalid at cycle %0d", host_q[0].due);
        void'(host_q.pop_front());
      end
      if (bus.acc_rd_valid_o != '0) begin
        total++;
        if (acc_q.size() == 0) begin
          bad++;
          $display("FAIL acc_rd_unexpected: valid=%b", bus.acc_rd_valid_o);
        end else begin
          acc_exp_t e;
          logic ok;
          e  = acc_q.pop_front();
          ok = (bus.acc_rd_valid_o == e.mask) && (cyc == e.due);
          for (int b = 0; b < int'(K); b++) begin
            if (e.mask[b] && (bus.acc_rd_data_o[b*DW +: DW] !== e.data[b*DW +: DW])) ok = 1'b0;
          end
          if (!ok) begin
            bad++;
            $display("FAIL acc_rd: got valid=%b data=%h cyc=%0d expected valid=%b data=%h cyc=%0d",
                     bus.acc_rd_valid_o, bus.acc_rd_data_o, cyc, e.mask, e.data, e.due);
          end
        end
      end
      if (bus.host_rvalid_o) begin
        total++;
        if (host_q.size() == 0) begin
          bad++;
          $display("FAIL host_rd_unexpected: rdata=%h", bus.host_rdata_o);
        end else begin
          host_exp_t h;
          h = host_q.pop_front();
          if (bus.host_rdata_o !== h.data || cyc != h.due) begin
            bad++;
            $display("FAIL host_rd: got %h cyc=%0d expected %h cyc=%0d",
                     bus.host_rdata_o, cyc, h.data, h.due);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [K*DW-1:0] v;
    int busy_cnt, done_cnt, gnt_bad;

    // Reset state, with a pending host request that must not be granted.
    rst = 1'b1;
    clr();
    bus.host_req_i = 1'b1;
    tick(); tick();
    check("rst_valid",   64'(bus.acc_rd_valid_o), 64'(0));
    check("rst_rdata",   64'(bus.acc_rd_data_o),  64'(0));
    check("rst_rvalid",  64'(bus.host_rvalid_o),  64'(0));
    check("rst_hrdata",  64'(bus.host_rdata_o),   64'(0));
    check("rst_busy",    64'(bus.clear_busy_o),   64'(0));
    check("rst_done",    64'(bus.clear_done_o),   64'(0));
    check("rst_err",     64'(bus.err_o),          64'(0));
    check("rst_gnt",     64'(bus.host_gnt_o),     64'(0));
    rst = 1'b0;
    clr();
    tick();

    // Single-bank write then read.
    set_wr(2, 4'd5, 8'h3C);
    tick(); clr();
    v = '0; v[2*DW +: DW] = 8'h3C;
    rd(6'b000100, 4'd5, v);
    tick(); clr(); tick();

    // All banks written and read back at one broadcast address.
    v = '0;
    for (int b = 0; b < int'(K); b++) begin
      set_wr(b, 4'd3, 8'(8'h30 + b));
      v[b*DW +: DW] = 8'(8'h30 + b);
    end
    tick(); clr();
    rd(6'b111111, 4'd3, v);
    tick(); clr(); tick();

    // Read-first collision on bank 0 address 7.
    set_wr(0, 4'd7, 8'h11);
    tick(); clr();
    set_wr(0, 4'd7, 8'h22);
    v = '0; v[7:0] = 8'h11;
    rd(6'b000001, 4'd7, v);
    tick(); clr();
    v = '0; v[7:0] = 8'h22;
    rd(6'b000001, 4'd7, v);
    tick(); clr(); tick();

    // Host write, then arbitration against accelerator reads on the same bank.
    host(1'b1, 3'd1, 4'd3, 8'h5A);
    #1;
    check("host_wr_gnt", 64'(bus.host_gnt_o), 64'(1));
    tick(); clr();
    v = '0; v[1*DW +: DW] = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      host(1'b0, 3'd1, 4'd3, 8'h00);
      rd(6'b000010, 4'd3, v);
      #1;
      check("host_blocked_gnt", 64'(bus.host_gnt_o), 64'(0));
      tick(); clr();
    end
    host(1'b0, 3'd1, 4'd3, 8'h00);
    #1;
    check("host_released_gnt", 64'(bus.host_gnt_o), 64'(1));
    host_expect(8'h5A);
    tick(); clr();

    // Host on a different bank is not blocked by accelerator traffic.
    rd(6'b000010, 4'd3, v);
    host(1'b0, 3'd0, 4'd3, 8'h00);
    #1;
    check("host_other_bank_gnt", 64'(bus.host_gnt_o), 64'(1));
    host_expect(8'h30);
    tick(); clr(); tick();

    // Host access to a non-existent bank.
    check("err_clean", 64'(bus.err_o), 64'(0));
    host(1'b1, 3'd7, 4'd3, 8'hEE);
    #1;
    check("bad_bank_wr_gnt", 64'(bus.host_gnt_o), 64'(1));
    tick(); clr();
    check("bad_bank_err", 64'(bus.err_o), 64'(1));
    host(1'b0, 3'd7, 4'd3, 8'h00);
    #1;
    check("bad_bank_rd_gnt", 64'(bus.host_gnt_o), 64'(1));
    host_expect(8'h00);
    tick(); clr();
    v = '0;
    for (int b = 0; b < int'(K); b++) v[b*DW +: DW] = 8'(8'h30 + b);
    v[1*DW +: DW] = 8'h5A;
    rd(6'b111111, 4'd3, v);
    tick(); clr(); tick();
    check("err_sticky", 64'(bus.err_o), 64'(1));

    // Preload every word, then sweep.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < int'(K); b++) set_wr(b, 4'(a), 8'(1 + a + 16 * b));
      tick(); clr();
    end
    bus.clear_start_i = 1'b1;
    tick(); clr();
    host(1'b0, 3'd0, 4'd0, 8'h00);
    v = '0;
    for (int b = 0; b < int'(K); b++) v[b*DW +: DW] = 8'(1 + 16 * b);
    rd(6'b111111, 4'd0, v);
    #1;
    check("clr_busy_first", 64'(bus.clear_busy_o), 64'(1));
    busy_cnt = 1; done_cnt = 0; gnt_bad = 0;
    if (bus.host_gnt_o) gnt_bad++;
    tick();
    for (int i = 0; i < 30; i++) begin
      bus.acc_rd_en_i = '0;
      #1;
      if (bus.clear_busy_o) begin
        busy_cnt++;
        if (bus.host_gnt_o) gnt_bad++;
      end
      if (bus.clear_done_o) begin
        done_cnt++;
        check("host_gnt_at_done", 64'(bus.host_gnt_o), 64'(1));
        bus.host_req_i = 1'b0;
      end
      tick();
    end
    clr();
    check("clr_busy_cycles", 64'(busy_cnt), 64'(16));
    check("clr_done_pulses", 64'(done_cnt), 64'(1));
    check("clr_host_gnt",    64'(gnt_bad),  64'(0));
    for (int a = 0; a < 16; a++) begin
      rd(6'b111111, 4'(a), '0);
      tick(); clr();
    end
    tick(); tick();

    // Reset in the fifth cycle of a sweep.
    bus.clear_start_i = 1'b1;
    tick(); clr();
    tick(); tick(); tick(); tick();
    check("mid_busy", 64'(bus.clear_busy_o), 64'(1));
    host(1'b0, 3'd0, 4'd0, 8'h00);
    rst = 1'b1;
    #1;
    check("mid_rst_busy",   64'(bus.clear_busy_o),   64'(0));
    check("mid_rst_done",   64'(bus.clear_done_o),   64'(0));
    check("mid_rst_err",    64'(bus.err_o),          64'(0));
    check("mid_rst_valid",  64'(bus.acc_rd_valid_o), 64'(0));
    check("mid_rst_rvalid", 64'(bus.host_rvalid_o),  64'(0));
    check("mid_rst_gnt",    64'(bus.host_gnt_o),     64'(0));
    clr();
    tick(); tick();
    rst = 1'b0;
    busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (bus.clear_busy_o) busy_cnt++;
      if (bus.clear_done_o) done_cnt++;
    end
    check("aborted_busy", 64'(busy_cnt), 64'(0));
    check("aborted_done", 64'(done_cnt), 64'(0));

    // Fresh sweep with an accelerator write landing on an already-cleared word.
    bus.clear_start_i = 1'b1;
    tick();
    busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      clr();
      if (i == 8) set_wr(3, 4'd2, 8'h77);
      #1;
      if (bus.clear_busy_o) busy_cnt++;
      if (bus.clear_done_o) done_cnt++;
      tick();
    end
    clr();
    check("clr2_busy_cycles", 64'(busy_cnt), 64'(16));
    check("clr2_done_pulses", 64'(done_cnt), 64'(1));
    check("clr2_err",         64'(bus.err_o), 64'(1));
    rd(6'b001000, 4'd2, '0);
    tick(); clr();
    tick(); tick(); tick();

    total++;
    if (acc_q.size() != 0 || host_q.size() != 0) begin
      bad++;
      $display("FAIL queues_drained: acc=%0d host=%0d left, expected 0", acc_q.size(), host_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
